// File: rtl/dma_request_arbiter.sv
// Round-robin front end of the shared-memory DMA engine: picks one toggled processor request,
// hands it to the engine and toggles that processor's ack once it is done. Optional watchdog: DMA_ARB_TIMEOUT_EN.
module dma_request_arbiter #(
    parameter int PROC_CNT = 4,
    parameter int ADDR_W   = 16,
    parameter int LEN_W    = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PROC_CNT-1:0]          trigger,
    output logic [PROC_CNT-1:0]          ack,
    input  logic [PROC_CNT*ADDR_W-1:0]   ptr,
    input  logic [PROC_CNT*ADDR_W-1:0]   copy_start,
    input  logic [PROC_CNT*LEN_W-1:0]    copy_length,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [$clog2(PROC_CNT)-1:0]  req_proc,
    output logic [ADDR_W-1:0]            req_ptr,
    output logic [ADDR_W-1:0]            req_start,
    output logic [LEN_W-1:0]             req_length,
    input  logic                         done,
    output logic                         busy,
    output logic                         error
);
    localparam int PIDX_W = $clog2(PROC_CNT);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, ACK} state_t;

    state_t              state_reg, state_next;
    logic [PROC_CNT-1:0] trigger_reg;
    logic [PROC_CNT-1:0] last_trigger_reg;
    logic [PROC_CNT-1:0] pend;
    logic [PIDX_W-1:0]   rr_ptr_reg;
    logic [PIDX_W-1:0]   grant_reg;
    logic [ADDR_W-1:0]   req_ptr_reg, req_start_reg;
    logic [LEN_W-1:0]    req_length_reg;
    logic [PROC_CNT-1:0] ack_reg;
    logic                grant_found;
    logic [PIDX_W-1:0]   grant_idx;
    logic [ADDR_W-1:0]   sel_ptr, sel_start;
    logic [LEN_W-1:0]    sel_len;
    logic                timeout_hit;

    // Pending compares the registered trigger so the edge detect adds one cycle of latency
    generate
        for (genvar gi = 0; gi < PROC_CNT; gi++) begin : g_pend
            assign pend[gi] = trigger_reg[gi] ^ last_trigger_reg[gi];
        end
    endgenerate

    // Scan downwards so the pending entry closest to rr_ptr is the last one written
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = PROC_CNT - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_reg) + k) % PROC_CNT;
            if (pend[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PIDX_W'(idx);
            end
        end
    end

    assign sel_ptr   = ptr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_start = copy_start[grant_idx*ADDR_W +: ADDR_W];
    assign sel_len   = copy_length[grant_idx*LEN_W +: LEN_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_found) state_next = (sel_len == '0) ? ACK : ISSUE;
            ISSUE:   if (req_ready) state_next = BUSY;
            BUSY:    if (done || timeout_hit) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_valid = (state_reg == ISSUE);
        busy      = (state_reg != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trigger_reg      <= trigger;
            last_trigger_reg <= trigger;
            rr_ptr_reg       <= '0;
            grant_reg        <= '0;
            req_ptr_reg      <= '0;
            req_start_reg    <= '0;
            req_length_reg   <= '0;
            ack_reg          <= '0;
        end else begin
            trigger_reg <= trigger;
            if (state_reg == IDLE && grant_found) begin
                grant_reg                   <= grant_idx;
                req_ptr_reg                 <= sel_ptr;
                req_start_reg               <= sel_start;
                req_length_reg              <= sel_len;
                // Only the toggle actually seen is consumed; a later one stays pending
                last_trigger_reg[grant_idx] <= trigger_reg[grant_idx];
            end
            if (state_reg == ACK) begin
                ack_reg[grant_reg] <= ~ack_reg[grant_reg];
                rr_ptr_reg         <= (grant_reg == PIDX_W'(PROC_CNT - 1)) ? '0 : grant_reg + 1'b1;
            end
        end
    end

    assign ack        = ack_reg;
    assign req_proc   = grant_reg;
    assign req_ptr    = req_ptr_reg;
    assign req_start  = req_start_reg;
    assign req_length = req_length_reg;

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_reg;
    logic             error_reg;

    // Counter holds zero outside BUSY, so it is cleared on every BUSY entry
    assign timeout_hit = (state_reg == BUSY) && (wd_cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            wd_cnt_reg <= (state_reg == BUSY) ? wd_cnt_reg + 1'b1 : '0;
            if (timeout_hit && !done) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign error = error_reg;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Randomized bench for dma_request_arbiter against a request-level round-robin model.
module tb_dma_request_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int LW = 16;
    localparam int TO = 16;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [N-1:0]          trigger;
    logic [N-1:0]          ack;
    logic [N*AW-1:0]       ptr;
    logic [N*AW-1:0]       copy_start;
    logic [N*LW-1:0]       copy_length;
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_proc;
    logic [AW-1:0]         req_ptr;
    logic [AW-1:0]         req_start;
    logic [LW-1:0]         req_length;
    logic                  done;
    logic                  busy;
    logic                  error;

    dma_request_arbiter #(
        .PROC_CNT(N), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .trigger(trigger), .ack(ack),
        .ptr(ptr), .copy_start(copy_start), .copy_length(copy_length),
        .req_valid(req_valid), .req_ready(req_ready), .req_proc(req_proc),
        .req_ptr(req_ptr), .req_start(req_start), .req_length(req_length),
        .done(done), .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    // Request-level model: outstanding requests, their parameters, rotation point, ack state
    bit            pend_m [N];
    logic [AW-1:0] mptr [N];
    logic [AW-1:0] mstart [N];
    logic [LW-1:0] mlen [N];
    int            rr_m;
    logic [N-1:0]  ack_m;
    logic [N-1:0]  trig;
    logic          err_m;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_len();
        if ($urandom_range(0, 3) == 0) return '0;
        return LW'($urandom_range(1, 200));
    endfunction

    function automatic int next_grant();
        for (int k = 0; k < N; k++) begin
            if (pend_m[(rr_m + k) % N]) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int k = 0; k < N; k++) if (pend_m[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic post(input int p, input logic [AW-1:0] a, input logic [AW-1:0] s, input logic [LW-1:0] l);
        mptr[p] = a;
        mstart[p] = s;
        mlen[p] = l;
        ptr[p*AW +: AW] = a;
        copy_start[p*AW +: AW] = s;
        copy_length[p*LW +: LW] = l;
        trig[p] = ~trig[p];
        trigger = trig;
        pend_m[p] = 1'b1;
        $display("post proc=%0d ptr=0x%0h start=0x%0h len=%0d", p, a, s, l);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) pend_m[k] = 1'b0;
        rr_m = 0;
        ack_m = '0;
        err_m = 1'b0;
    endtask

    // Serves the model's next grant, acting as the engine; rdy_d < 0 picks a random ready delay
    task automatic serve_one(input bit late_ok, input int rdy_d);
        int g, n, d;
        g = next_grant();
        if (g < 0) return;
        if (mlen[g] != '0) begin
            n = 0;
            while (!req_valid && n < 20) begin
                step();
                n++;
            end
            check_val("req_valid_seen", req_valid, 1);
            check_val("req_proc", req_proc, g);
            check_val("req_ptr", req_ptr, mptr[g]);
            check_val("req_start", req_start, mstart[g]);
            check_val("req_length", req_length, mlen[g]);
            ptr[g*AW +: AW] = ~mptr[g];
            copy_start[g*AW +: AW] = ~mstart[g];
            copy_length[g*LW +: LW] = ~mlen[g];
            d = (rdy_d < 0) ? $urandom_range(0, 4) : rdy_d;
            repeat (d) begin
                step();
                check_val("hold_valid", req_valid, 1);
                check_val("hold_ptr", req_ptr, mptr[g]);
                check_val("hold_length", req_length, mlen[g]);
            end
            req_ready = 1'b1;
            step();
            req_ready = 1'b0;
            check_val("valid_drop", req_valid, 0);
            check_val("busy_in_flight", busy, 1);
            if (late_ok) begin
                for (int q = 0; q < N; q++) begin
                    if (q != g && !pend_m[q] && $urandom_range(0, 1) == 1) begin
                        post(q, AW'($urandom), AW'($urandom), rand_len());
                    end
                end
            end
            d = $urandom_range(0, 5);
            repeat (d) step();
            done = 1'b1;
            step();
            done = 1'b0;
            check_val("ack_not_early", ack, ack_m);
            step();
        end else begin
            n = 0;
            while (ack === ack_m && n < 10) begin
                check_val("zero_len_no_valid", req_valid, 0);
                step();
                n++;
            end
        end
        ack_m[g] = ~ack_m[g];
        check_val("ack", ack, ack_m);
        check_val("error", error, err_m);
        $display("served proc=%0d len=%0d ack=%b", g, mlen[g], ack);
        pend_m[g] = 1'b0;
        rr_m = (g + 1) % N;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, iter;
        logic [N-1:0] mask;

        reset = 1'b1;
        trig = 4'b0101;
        trigger = trig;
        ptr = '0;
        copy_start = '0;
        copy_length = '0;
        req_ready = 1'b0;
        done = 1'b0;
        model_reset();
        for (int k = 0; k < N; k++) begin
            mptr[k] = '0;
            mstart[k] = '0;
            mlen[k] = '0;
        end
        repeat (3) step();
        reset = 1'b0;

        // Reset state and a quiet idle with a non-zero trigger level
        check_val("rst_req_proc", req_proc, 0);
        check_val("rst_req_ptr", req_ptr, 0);
        check_val("rst_req_length", req_length, 0);
        check_val("rst_error", error, 0);
        for (int k = 0; k < 10; k++) begin
            check_val("rst_no_valid", req_valid, 0);
            check_val("rst_ack", ack, 0);
            check_val("rst_busy", busy, 0);
            step();
        end

        // Trigger-to-valid latency of two cycles
        post(2, 16'h0100, 16'h0010, 16'd8);
        step();
        check_val("latency_early", req_valid, 0);
        step();
        check_val("latency_2", req_valid, 1);
        serve_one(1'b0, 0);

        // Zero-length request bypasses the engine
        post(1, AW'($urandom), AW'($urandom), '0);
        step();
        serve_one(1'b0, -1);

        // Engine stalls six cycles while the source pointer changes
        post(1, 16'h1234, 16'h0040, 16'd20);
        step();
        serve_one(1'b0, 6);

        // Stray done while idle is ignored
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        check_val("stray_done_ack", ack, ack_m);
        check_val("stray_done_busy", busy, 0);

        // Reset mid-flight abandons the request; a toggle during reset is dropped
        post(0, 16'h0aaa, 16'h0bbb, 16'd10);
        step();
        n = 0;
        while (!req_valid && n < 20) begin
            step();
            n++;
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        step();
        reset = 1'b1;
        trig[3] = ~trig[3];
        trigger = trig;
        step();
        step();
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            step();
            check_val("midrst_no_valid", req_valid, 0);
            check_val("midrst_ack", ack, 0);
            check_val("midrst_busy", busy, 0);
        end

        // All four at once from rr_ptr=0
        for (int p = 0; p < N; p++) post(p, AW'($urandom), AW'($urandom), LW'($urandom_range(1, 100)));
        step();
        for (int k = 0; k < N; k++) serve_one(1'b0, -1);

`ifdef DMA_ARB_TIMEOUT_EN
        // Watchdog expiry releases the processor and sets the sticky error
        post(3, 16'h0300, 16'h0030, 16'd5);
        step();
        n = 0;
        while (!req_valid && n < 20) begin
            step();
            n++;
        end
        check_val("to_valid", req_valid, 1);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        n = 0;
        while (ack === ack_m && n < 40) begin
            step();
            n++;
        end
        check_val("timeout_cycles", n, TO + 1);
        ack_m[3] = ~ack_m[3];
        err_m = 1'b1;
        check_val("timeout_ack", ack, ack_m);
        check_val("timeout_error", error, 1);
        pend_m[3] = 1'b0;
        rr_m = 0;
        post(0, 16'h0400, 16'h0040, 16'd3);
        step();
        serve_one(1'b0, -1);
`endif

        // Randomized batches with occasional late arrivals during BUSY
        for (int b = 0; b < 25; b++) begin
            check_val("batch_idle", busy, 0);
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int p = 0; p < N; p++) begin
                if (mask[p]) post(p, AW'($urandom), AW'($urandom), rand_len());
            end
            step();
            iter = 0;
            while (any_pending() && iter < 40) begin
                serve_one($urandom_range(0, 2) == 0, -1);
                iter++;
            end
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
